// File: rtl/nasti_lite_read_arbiter.sv
// Round-robin N:1 arbiter for nasti-lite read channels. R beats are routed back
// through an in-order FIFO of granted master indices, never by the id value.
module nasti_lite_read_arbiter #(
    parameter int N_MASTER        = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 13,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_MASTER*ID_WIDTH-1:0]   m_ar_id,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] m_ar_addr,
    input  logic [N_MASTER-1:0]            m_ar_valid,
    output logic [N_MASTER-1:0]            m_ar_ready,
    output logic [ID_WIDTH-1:0]            m_r_id,
    output logic [DATA_WIDTH-1:0]          m_r_data,
    output logic [1:0]                     m_r_resp,
    output logic [N_MASTER-1:0]            m_r_valid,
    input  logic [N_MASTER-1:0]            m_r_ready,
    output logic [ID_WIDTH-1:0]            s_ar_id,
    output logic [ADDR_WIDTH-1:0]          s_ar_addr,
    output logic                           s_ar_valid,
    input  logic                           s_ar_ready,
    input  logic [ID_WIDTH-1:0]            s_r_id,
    input  logic [DATA_WIDTH-1:0]          s_r_data,
    input  logic [1:0]                     s_r_resp,
    input  logic                           s_r_valid,
    output logic                           s_r_ready
);
    localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam logic [IDX_W-1:0] LAST_M = IDX_W'(N_MASTER - 1);
    localparam logic [PTR_W-1:0] LAST_P = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(MAX_OUTSTANDING);

    logic                 state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     lock_grant;
    logic [IDX_W-1:0]     rr_pick;
    logic [IDX_W-1:0]     cand;
    logic                 found;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ar_hs;
    logic                 r_hs;

    // First asserted valid at or after rr_ptr, wrapping around the masters.
    always_comb begin
        rr_pick = rr_ptr;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_MASTER);
            if (!found && m_ar_valid[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    end

    assign grant      = (state == ST_LOCKED) ? lock_grant : rr_pick;
    assign fifo_full  = (count == FULL_C);
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // Handshake outputs are forced low while reset is asserted.
    assign s_ar_valid = rstn & m_ar_valid[grant] & ~fifo_full;
    assign s_ar_id    = m_ar_id[int'(grant)*ID_WIDTH +: ID_WIDTH];
    assign s_ar_addr  = m_ar_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign ar_hs      = s_ar_valid & s_ar_ready;

    always_comb begin
        m_ar_ready        = '0;
        m_ar_ready[grant] = rstn & s_ar_ready & ~fifo_full;
    end

    always_comb begin
        m_r_valid       = '0;
        m_r_valid[head] = rstn & s_r_valid & ~fifo_empty;
    end

    assign s_r_ready = rstn & ~fifo_empty & m_r_ready[head];
    assign r_hs      = s_r_valid & s_r_ready;
    assign m_r_id    = s_r_id;
    assign m_r_data  = s_r_data;
    assign m_r_resp  = s_r_resp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            lock_grant <= '0;
        end else begin
            if (ar_hs) begin
                rr_ptr <= (grant == LAST_M) ? '0 : grant + IDX_W'(1);
                state  <= ST_IDLE;
            end else if (state == ST_IDLE && s_ar_valid) begin
                // Slave stalled: hold this grant so the AR payload stays stable.
                state      <= ST_LOCKED;
                lock_grant <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ar_hs) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PTR_W'(1);
            if (r_hs)  rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PTR_W'(1);
            case ({ar_hs, r_hs})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) fifo_mem[wr_ptr] <= grant;
    end
endmodule

// File: tb/tb_nasti_lite_read_arbiter.sv
// Bench for nasti_lite_read_arbiter: directed scenarios with fixed expectations
// plus a randomized run checked against an ordered-queue reference model.
module tb_nasti_lite_read_arbiter;
    localparam int N  = 2;
    localparam int IW = 4;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int XW = 1;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N*IW-1:0] m_ar_id;
    logic [N*AW-1:0] m_ar_addr;
    logic [N-1:0]    m_ar_valid;
    logic [N-1:0]    m_ar_ready;
    logic [IW-1:0]   m_r_id;
    logic [DW-1:0]   m_r_data;
    logic [1:0]      m_r_resp;
    logic [N-1:0]    m_r_valid;
    logic [N-1:0]    m_r_ready;
    logic [IW-1:0]   s_ar_id;
    logic [AW-1:0]   s_ar_addr;
    logic            s_ar_valid;
    logic            s_ar_ready;
    logic [IW-1:0]   s_r_id;
    logic [DW-1:0]   s_r_data;
    logic [1:0]      s_r_resp;
    logic            s_r_valid;
    logic            s_r_ready;

    nasti_lite_read_arbiter #(
        .N_MASTER(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid),
        .m_ar_ready(m_ar_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid),
        .s_ar_ready(s_ar_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: outstanding reads in acceptance order, next-priority
    // master, and whether a stalled request currently owns the AR channel.
    logic [XW-1:0] exp_q[$];
    int            mdl_rr;
    bit            mdl_locked;
    int            mdl_lock_m;
    int            e_grant;
    bit            e_sav;
    bit            e_srr;
    logic [N-1:0]  e_mar;
    logic [N-1:0]  e_mrv;
    logic [N-1:0]  acc;

    function automatic void model_eval();
        bit full;
        if (mdl_locked) e_grant = mdl_lock_m;
        else begin
            e_grant = mdl_rr;
            for (int i = N - 1; i >= 0; i--)
                if (m_ar_valid[(mdl_rr + i) % N]) e_grant = (mdl_rr + i) % N;
        end
        full  = (exp_q.size() == MO);
        e_sav = m_ar_valid[e_grant] && !full;
        e_mar = '0;
        if (s_ar_ready && !full) e_mar[e_grant] = 1'b1;
        e_mrv = '0;
        e_srr = 1'b0;
        if (exp_q.size() > 0) begin
            if (s_r_valid) e_mrv[exp_q[0]] = 1'b1;
            e_srr = m_r_ready[exp_q[0]];
        end
    endfunction

    task automatic advance();
        bit ar_hs, r_hs;
        model_eval();
        ar_hs = e_sav && s_ar_ready;
        r_hs  = e_srr && s_r_valid;
        acc   = '0;
        @(posedge clk);
        if (r_hs) void'(exp_q.pop_front());
        if (ar_hs) begin
            exp_q.push_back(XW'(e_grant));
            mdl_rr     = (e_grant + 1) % N;
            mdl_locked = 1'b0;
            acc[e_grant] = 1'b1;
        end else if (e_sav) begin
            mdl_locked = 1'b1;
            mdl_lock_m = e_grant;
        end
        #1;
    endtask

    task automatic idle_inputs();
        m_ar_valid = '0; m_ar_id = '0; m_ar_addr = '0;
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_id = '0;
        s_r_data = '0; s_r_resp = '0; m_r_ready = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        exp_q.delete();
        mdl_rr = 0; mdl_locked = 1'b0; mdl_lock_m = 0; acc = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        m_ar_valid = '1; s_ar_ready = 1'b1; s_r_valid = 1'b1; m_r_ready = '1;
        #3;
        checks++;
        if ({s_ar_valid, m_ar_ready, m_r_valid, s_r_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {s_ar_valid, m_ar_ready, m_r_valid, s_r_ready});
        end
        do_reset();
    endtask

    task automatic test_alternate();
        logic [N-1:0] alt_tbl [4];
        logic [N-1:0] drain_tbl [4];
        alt_tbl   = '{2'b01, 2'b10, 2'b01, 2'b10};
        drain_tbl = '{2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        m_ar_valid = 2'b11; s_ar_ready = 1'b1; m_r_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (m_ar_ready !== alt_tbl[k] || s_ar_valid !== 1'b1) begin
                failures++;
                $display("FAIL alternate_grant[%0d] got=%b/%b exp=%b/1", k, m_ar_ready, s_ar_valid, alt_tbl[k]);
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (s_ar_valid !== 1'b0 || m_ar_ready !== 2'b00) begin
            failures++;
            $display("FAIL full_blocks got=%b/%b exp=0/00", s_ar_valid, m_ar_ready);
        end
        advance();
        s_r_valid = 1'b1; s_r_data = 32'h11;
        @(negedge clk);
        checks++;
        if (s_ar_valid !== 1'b0 || m_r_valid !== 2'b01 || s_r_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_same_cycle got=%b/%b/%b exp=0/01/1", s_ar_valid, m_r_valid, s_r_ready);
        end
        advance();
        s_r_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ar_valid !== 1'b1 || m_ar_ready !== 2'b01) begin
            failures++;
            $display("FAIL resume_after_pop got=%b/%b exp=1/01", s_ar_valid, m_ar_ready);
        end
        advance();
        m_ar_valid = '0; s_r_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_r_data = 32'h100 + k;
            @(negedge clk);
            checks++;
            if (m_r_valid !== drain_tbl[k] || m_r_data !== 32'h100 + k) begin
                failures++;
                $display("FAIL drain_route[%0d] got=%b/%0h exp=%b/%0h", k, m_r_valid, m_r_data, drain_tbl[k], 32'h100 + k);
            end
            advance();
        end
    endtask

    task automatic test_lock();
        do_reset();
        m_ar_valid = 2'b01; m_ar_addr[0 +: AW] = 13'h0AA; s_ar_ready = 1'b1;
        advance();
        m_ar_addr[0 +: AW] = 13'h123; s_ar_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin m_ar_valid = 2'b11; m_ar_addr[AW +: AW] = 13'h456; end
            @(negedge clk);
            checks++;
            if (s_ar_addr !== 13'h123 || s_ar_valid !== 1'b1) begin
                failures++;
                $display("FAIL locked_addr[%0d] got=%0h/%b exp=123/1", k, s_ar_addr, s_ar_valid);
            end
            advance();
        end
        s_ar_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ar_ready !== 2'b01) begin
            failures++;
            $display("FAIL locked_handshake got=%b exp=01", m_ar_ready);
        end
        advance();
        m_ar_valid = 2'b10;
        @(negedge clk);
        checks++;
        if (m_ar_ready !== 2'b10 || s_ar_addr !== 13'h456) begin
            failures++;
            $display("FAIL after_lock got=%b/%0h exp=10/456", m_ar_ready, s_ar_addr);
        end
        advance();
    endtask

    task automatic test_order();
        logic [N-1:0]  ar_tbl [3];
        logic [N-1:0]  r_tbl [3];
        logic [DW-1:0] d_tbl [3];
        ar_tbl = '{2'b10, 2'b01, 2'b10};
        r_tbl  = '{2'b10, 2'b01, 2'b10};
        d_tbl  = '{32'hA, 32'hB, 32'hC};
        do_reset();
        s_ar_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_ar_valid = ar_tbl[k];
            advance();
        end
        m_ar_valid = '0;
        s_r_valid = 1'b1; s_r_data = 32'hA; m_r_ready = 2'b01;
        @(negedge clk);
        checks++;
        if (s_r_ready !== 1'b0 || m_r_valid !== 2'b10 || m_r_data !== 32'hA) begin
            failures++;
            $display("FAIL r_stall got=%b/%b/%0h exp=0/10/a", s_r_ready, m_r_valid, m_r_data);
        end
        advance();
        m_r_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            s_r_data = d_tbl[k];
            @(negedge clk);
            checks++;
            if (m_r_valid !== r_tbl[k] || m_r_data !== d_tbl[k] || s_r_ready !== 1'b1) begin
                failures++;
                $display("FAIL r_order[%0d] got=%b/%0h/%b exp=%b/%0h/1", k, m_r_valid, m_r_data, s_r_ready, r_tbl[k], d_tbl[k]);
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (s_r_ready !== 1'b0 || m_r_valid !== 2'b00) begin
            failures++;
            $display("FAIL r_spurious got=%b/%b exp=0/00", s_r_ready, m_r_valid);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        m_ar_valid = 2'b11; s_ar_ready = 1'b1;
        advance();
        advance();
        m_r_ready = 2'b11; s_r_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({s_ar_valid, m_ar_ready, m_r_valid, s_r_ready} !== '0) begin
            failures++;
            $display("FAIL reset_inflight got=%b exp=0", {s_ar_valid, m_ar_ready, m_r_valid, s_r_ready});
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        exp_q.delete();
        mdl_rr = 0; mdl_locked = 1'b0;
        @(negedge clk);
        checks++;
        if (s_r_ready !== 1'b0 || m_r_valid !== 2'b00 || s_ar_valid !== 1'b1 || m_ar_ready !== 2'b01) begin
            failures++;
            $display("FAIL after_reset got=%b/%b/%b/%b exp=0/00/1/01", s_r_ready, m_r_valid, s_ar_valid, m_ar_ready);
        end
        advance();
    endtask

    task automatic test_random();
        logic [AW-1:0] g_addr;
        logic [IW-1:0] g_id;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_ar_valid[i] || acc[i]) begin
                    m_ar_valid[i]         = ($urandom_range(0, 2) != 0);
                    m_ar_addr[i*AW +: AW] = AW'($urandom);
                    m_ar_id[i*IW +: IW]   = IW'($urandom);
                end
            end
            s_ar_ready = ($urandom_range(0, 3) != 0);
            s_r_valid  = ($urandom_range(0, 2) != 0);
            s_r_data   = $urandom;
            s_r_id     = IW'($urandom);
            s_r_resp   = 2'($urandom);
            m_r_ready  = N'($urandom);
            @(negedge clk);
            model_eval();
            g_addr = m_ar_addr[e_grant*AW +: AW];
            g_id   = m_ar_id[e_grant*IW +: IW];
            checks++;
            if (s_ar_valid !== e_sav || m_ar_ready !== e_mar) begin
                failures++;
                $display("FAIL rnd_ar c=%0d got=%b/%b exp=%b/%b", c, s_ar_valid, m_ar_ready, e_sav, e_mar);
            end
            if (e_sav) begin
                checks++;
                if (s_ar_addr !== g_addr || s_ar_id !== g_id) begin
                    failures++;
                    $display("FAIL rnd_payload c=%0d got=%0h/%0h exp=%0h/%0h", c, s_ar_addr, s_ar_id, g_addr, g_id);
                end
            end
            checks++;
            if (m_r_valid !== e_mrv || s_r_ready !== e_srr) begin
                failures++;
                $display("FAIL rnd_r c=%0d got=%b/%b exp=%b/%b", c, m_r_valid, s_r_ready, e_mrv, e_srr);
            end
            checks++;
            if (m_r_data !== s_r_data || m_r_id !== s_r_id || m_r_resp !== s_r_resp) begin
                failures++;
                $display("FAIL rnd_broadcast c=%0d got=%0h exp=%0h", c, m_r_data, s_r_data);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_order();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
